// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int KP_ROWS = 4;
   localparam int KP_COLS = 4;

   typedef logic [3:0] kp_code_t;

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      EMIT         = 2'd2,
      WAIT_RELEASE = 2'd3
   } kp_state_e;

   // Index of the lowest active-low row; 0 when no row is low (caller qualifies).
   function automatic logic [1:0] lowest_low(input logic [KP_ROWS-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = KP_ROWS - 1; i >= 0; i--) begin
         idx = (!rows[i]) ? 2'(i) : idx;
      end
      return idx;
   endfunction

   // One-cold, active-low drive pattern for the selected column.
   function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] col);
      return ~(4'b0001 << col);
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_tick.sv
// scan_tick_gen: free-running divider producing a one-cycle tick every TICK_DIV clocks.
module scan_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q, count_d;
   logic          tick_q, tick_d;

   // Next count wraps at CNT_MAX; the tick flop is high while the count sits at CNT_MAX.
   always_comb begin
      if (count_q == CNT_MAX) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(1);
      end
      tick_d = (count_d == CNT_MAX);
   end

   // Divider state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and valid/ready output.
// Optional auto-repeat is built when the macro KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int TICK_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held
);

   localparam int            DW      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_SCANS);
   localparam logic          DEB_ONE = (DEBOUNCE_SCANS == 1);

   kp_state_e     state_q, state_d;
   logic [3:0]    rows_meta_q, rows_sync_q, rows_s;
   logic [1:0]    col_q, col_d, row_q, row_d, lowest_s;
   logic [DW-1:0] cnt_q, cnt_d, cnt_inc_s;
   logic          any_low_s, row_low_s, tick_s;
   logic [3:0]    col_out_q, col_out_d;
   kp_code_t      key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d, key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(RPT_TOP + 1);
   localparam logic [RW-1:0] RPT_DELAY_V = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RPT_RATE_V  = RW'(REPEAT_RATE);
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc_s;
   logic          rpt_first_q, rpt_first_d;
`else
   logic unused_repeat_cfg_s;
   assign unused_repeat_cfg_s = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

   scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_s)
   );

   assign rows_s    = rows_sync_q;
   assign lowest_s  = lowest_low(rows_s);
   assign any_low_s = ~&rows_s;
   assign row_low_s = ~rows_s[row_q];
   assign cnt_inc_s = cnt_q + DW'(1);

   // State register plus synchroniser and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rows_meta_q <= 4'hF;
         rows_sync_q <= 4'hF;
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         cnt_q       <= '0;
         col_out_q   <= 4'b1110;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         rows_meta_q <= row_in;
         rows_sync_q <= rows_meta_q;
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         col_out_q   <= col_out_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   assign rpt_inc_s = rpt_cnt_q + RW'(1);

   // Auto-repeat hold counter and first-repeat flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
      end
   end
`endif

   // Next-state logic: decisions on tick, except the EMIT handshake.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
`endif
      case (state_q)
         SCAN: begin
            if (tick_s && any_low_s) begin
               row_d = lowest_s;
               cnt_d = DW'(1);
               if (DEB_ONE) begin
                  state_d = EMIT;
`ifdef KEYPAD_REPEAT_EN
                  rpt_first_d = 1'b1;
`endif
               end else begin
                  state_d = DEBOUNCE;
               end
            end else if (tick_s) begin
               col_d = col_q + 2'd1;
            end else begin
               state_d = SCAN;
            end
         end
         DEBOUNCE: begin
            if (tick_s && any_low_s && (lowest_s == row_q)) begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == DEB_MAX) begin
                  state_d = EMIT;
`ifdef KEYPAD_REPEAT_EN
                  rpt_first_d = 1'b1;
`endif
               end else begin
                  state_d = DEBOUNCE;
               end
            end else if (tick_s) begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
            end else begin
               state_d = DEBOUNCE;
            end
         end
         EMIT: begin
            // Release during EMIT is ignored; only the handshake leaves.
            if (key_valid_q && key_ready) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
               rpt_cnt_d = '0;
`endif
            end else begin
               state_d = EMIT;
            end
         end
         WAIT_RELEASE: begin
            if (tick_s && !row_low_s) begin
`ifdef KEYPAD_REPEAT_EN
               rpt_cnt_d = '0;
`endif
               if (cnt_inc_s == DEB_MAX) begin
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end else if (tick_s) begin
               cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
               if (rpt_inc_s == (rpt_first_q ? RPT_DELAY_V : RPT_RATE_V)) begin
                  state_d     = EMIT;
                  rpt_cnt_d   = '0;
                  rpt_first_d = 1'b0;
               end else begin
                  rpt_cnt_d = rpt_inc_s;
               end
`endif
            end else begin
               state_d = WAIT_RELEASE;
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   // Output logic: registered outputs follow the next state.
   always_comb begin
      key_valid_d = (state_d == EMIT);
      key_held_d  = (state_d != SCAN);
      col_out_d   = col_drive(col_d);
      if (state_d == EMIT) begin
         key_code_d = {row_d, col_d};
      end else begin
         key_code_d = key_code_q;
      end
   end

   assign col_out   = col_out_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with a matrix keypad model and a transfer scoreboard.
module tb_keypad_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_out, key_code;
   logic        key_valid, key_held;
   logic        key_ready = 1'b1;
   logic [15:0] keys = 16'h0000;

   int total = 0;
   int bad = 0;
   int xfer_cnt = 0;
   int cyc = 0;
   int xfer_time[$];
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .TICK_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .REPEAT_DELAY   (5),
      .REPEAT_RATE    (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held)
   );

   // Keypad matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_xfer(input int target, input int limit, input string name);
      int n = 0;
      while (xfer_cnt < target && n < limit) begin
         step(1);
         n++;
      end
      check(name, int'(xfer_cnt >= target), 1);
   endtask

   task automatic wait_valid(input int limit, input string name);
      int n = 0;
      while (key_valid !== 1'b1 && n < limit) begin
         step(1);
         n++;
      end
      check(name, int'(key_valid === 1'b1), 1);
   endtask

   // Monitor: pop expected code on every transfer seen at the falling edge.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset && key_valid === 1'b1 && key_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_xfer", int'(key_code), -1);
            end else begin
               e = exp_q.pop_front();
               check("xfer_code", int'(key_code), int'(e));
            end
            xfer_time.push_back(cyc);
            xfer_cnt++;
         end
      end
   end

   initial begin
      logic [3:0] col_seq [5];
      int base;
      int n;
      bit stable;
      col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

      // 1: reset state and idle column walk
      step(3);
      check("rst_col_out", int'(col_out), int'(4'b1110));
      check("rst_key_valid", int'(key_valid), 0);
      check("rst_key_code", int'(key_code), 0);
      check("rst_key_held", int'(key_held), 0);
      reset = 1'b0;
      n = 0;
      while (col_out === 4'b1110 && n < 10) begin
         step(1);
         n++;
      end
      check("scan_first_step", int'(col_out !== 4'b1110), 1);
      for (int k = 1; k < 5; k++) begin
         check("scan_col", int'(col_out), int'(col_seq[k]));
         step(3);
         check("scan_hold", int'(col_out), int'(col_seq[k]));
         step(1);
      end

      // 2: key 9 (row 2, col 1), one transfer per press
      base = xfer_cnt;
      exp_q.push_back(4'd9);
      keys[9] = 1'b1;
      wait_xfer(base + 1, 80, "t2_xfer_timeout");
`ifndef KEYPAD_REPEAT_EN
      step(60);
      check("t2_single_xfer", xfer_cnt, base + 1);
      check("t2_held", int'(key_held), 1);
`endif
      keys = 16'h0000;
      step(40);
      check("t2_released", int'(key_held), 0);

      // 3: bounce key 3 (row 0, col 3), then stable
      base = xfer_cnt;
      for (int i = 0; i < 6; i++) begin
         keys[3] = 1'b1;
         step(4);
         keys[3] = 1'b0;
         step(4);
      end
      step(12);
      check("t3_no_bounce_out", xfer_cnt, base);
      exp_q.push_back(4'd3);
      keys[3] = 1'b1;
      wait_xfer(base + 1, 80, "t3_xfer_timeout");
      keys = 16'h0000;
      step(40);
      check("t3_released", int'(key_held), 0);

      // 4: stalled consumer holds the code; release during EMIT ignored
      base = xfer_cnt;
      key_ready = 1'b0;
      exp_q.push_back(4'd6);
      keys[6] = 1'b1;
      wait_valid(80, "t4_valid_timeout");
      check("t4_code", int'(key_code), 6);
      keys = 16'h0000;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (key_valid !== 1'b1 || key_code !== 4'd6) stable = 1'b0;
      end
      check("t4_stall_stable", int'(stable), 1);
      key_ready = 1'b1;
      step(1);
      check("t4_valid_drop", int'(key_valid), 0);
      check("t4_xfer_once", xfer_cnt, base + 1);
      check("t4_wait_release_held", int'(key_held), 1);
      check("t4_col_frozen", int'(col_out), int'(4'b1011));
      step(40);
      check("t4_released", int'(key_held), 0);

      // 5: reset during EMIT discards the code
      base = xfer_cnt;
      key_ready = 1'b0;
      keys[12] = 1'b1;
      wait_valid(80, "t5_valid_timeout");
      reset = 1'b1;
      step(1);
      check("t5_valid_cleared", int'(key_valid), 0);
      check("t5_col_reset", int'(col_out), int'(4'b1110));
      check("t5_held_cleared", int'(key_held), 0);
      keys = 16'h0000;
      reset = 1'b0;
      key_ready = 1'b1;
      step(60);
      check("t5_no_delivery", xfer_cnt, base);

`ifdef KEYPAD_REPEAT_EN
      // 6: auto-repeat of key 5: first repeat 5 ticks later, then every 2
      base = xfer_cnt;
      for (int i = 0; i < 4; i++) exp_q.push_back(4'd5);
      keys[5] = 1'b1;
      wait_xfer(base + 4, 200, "t6_xfer_timeout");
      keys = 16'h0000;
      step(40);
      check("t6_repeat_stops", xfer_cnt, base + 4);
      if (xfer_time.size() >= base + 4) begin
         check("t6_delay", xfer_time[base+1] - xfer_time[base], 20);
         check("t6_rate1", xfer_time[base+2] - xfer_time[base+1], 8);
         check("t6_rate2", xfer_time[base+3] - xfer_time[base+2], 8);
      end
      check("t6_released", int'(key_held), 0);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
